// File: rtl/serial_tx.sv
`default_nettype none
// ============================================================================
// Module   : serial_tx
// Purpose  : Framed serial transmitter. It accepts a parallel word over a
//            valid/ready handshake and sends a start bit, then the data bits
//            LSB first, then a stop bit. Each bit is held on the line for
//            CLKS_PER_BIT clock cycles.
// Revision : 1.0 - initial release
// ============================================================================
module serial_tx #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic                  clk,
    input  logic                  i_rst,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_valid,
    output logic                  o_ready,
    output logic                  o_tx,
    output logic                  o_busy,
    output logic                  o_done
);

    localparam int c_BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int c_BIT_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_START = 2'd1;
    localparam logic [1:0] c_DATA  = 2'd2;
    localparam logic [1:0] c_STOP  = 2'd3;

    // Last baud count of a bit, and the count one before it. The second
    // value lets o_done be registered so that it rises exactly on the final
    // stop cycle. When CLKS_PER_BIT is 1, this value wraps and is never
    // used, because every STOP cycle is then the terminal one.
    localparam logic [c_BAUD_W-1:0] c_BAUD_LAST = c_BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [c_BAUD_W-1:0] c_BAUD_PRE  = c_BAUD_W'(CLKS_PER_BIT - 2);
    localparam logic [c_BIT_W-1:0]  c_BIT_LAST  = c_BIT_W'(DATA_WIDTH - 1);

    logic [1:0]            r_state;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [c_BAUD_W-1:0]   r_baud;
    logic [c_BIT_W-1:0]    r_bit;
    logic                  r_tx;
    logic                  r_done;

    logic                  w_baud_end;
    logic [DATA_WIDTH-1:0] w_shift_next;

    assign w_baud_end   = (r_baud == c_BAUD_LAST);
    assign w_shift_next = r_shift >> 1;

    // Handshake and status decode. Reset masks ready so that a word offered
    // during reset is never reported as accepted.
    assign o_ready = (r_state == c_IDLE) && !i_rst;
    assign o_busy  = (r_state != c_IDLE);
    assign o_tx    = r_tx;
    assign o_done  = r_done;

    // Frame sequencer. r_tx is loaded one edge ahead, with the level the
    // line must carry in the next cycle.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_state <= c_IDLE;
            r_shift <= '0;
            r_baud  <= '0;
            r_bit   <= '0;
            r_tx    <= 1'b1;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    r_tx <= 1'b1;
                    if (i_valid) begin
                        r_shift <= i_data;
                        r_baud  <= '0;
                        r_bit   <= '0;
                        r_tx    <= 1'b0;
                        r_state <= c_START;
                    end
                end

                c_START: begin
                    if (w_baud_end) begin
                        r_baud  <= '0;
                        r_tx    <= r_shift[0];
                        r_state <= c_DATA;
                    end else begin
                        r_baud <= r_baud + c_BAUD_W'(1);
                    end
                end

                c_DATA: begin
                    if (w_baud_end) begin
                        r_baud  <= '0;
                        r_shift <= w_shift_next;
                        if (r_bit == c_BIT_LAST) begin
                            r_bit   <= '0;
                            r_tx    <= 1'b1;
                            r_done  <= (CLKS_PER_BIT == 1);
                            r_state <= c_STOP;
                        end else begin
                            r_bit <= r_bit + c_BIT_W'(1);
                            r_tx  <= w_shift_next[0];
                        end
                    end else begin
                        r_baud <= r_baud + c_BAUD_W'(1);
                    end
                end

                c_STOP: begin
                    r_tx <= 1'b1;
                    if (w_baud_end) begin
                        r_baud  <= '0;
                        r_state <= c_IDLE;
                    end else begin
                        r_baud <= r_baud + c_BAUD_W'(1);
                        r_done <= (r_baud == c_BAUD_PRE);
                    end
                end

                default: begin
                    r_tx    <= 1'b1;
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_tx
// Purpose  : Directed self-checking bench for serial_tx. Instance A uses
//            8 data bits and 4 clocks per bit. Instance B uses 4 data bits
//            and 1 clock per bit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] a_data;
    logic       a_valid;
    logic       a_ready, a_tx, a_busy, a_done;
    logic [3:0] b_data;
    logic       b_valid;
    logic       b_ready, b_tx, b_busy, b_done;

    int n_tests = 0;
    int n_fail  = 0;

    serial_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(4)) u_dut_a (
        .clk     (clk),
        .i_rst   (rst),
        .i_data  (a_data),
        .i_valid (a_valid),
        .o_ready (a_ready),
        .o_tx    (a_tx),
        .o_busy  (a_busy),
        .o_done  (a_done)
    );

    serial_tx #(.DATA_WIDTH(4), .CLKS_PER_BIT(1)) u_dut_b (
        .clk     (clk),
        .i_rst   (rst),
        .i_data  (b_data),
        .i_valid (b_valid),
        .o_ready (b_ready),
        .o_tx    (b_tx),
        .o_busy  (b_busy),
        .o_done  (b_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_tests++;
        if (obs !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, want);
        end
    endtask

    // Expected line level for instance A in frame cycle k (1..40).
    function automatic logic exp_tx8(input logic [7:0] d, input int k);
        int b;
        b = (k - 1) / 4;
        if (b == 0) return 1'b0;
        if (b <= 8) return d[b-1];
        return 1'b1;
    endfunction

    // Sends one full frame on instance A and checks it cycle by cycle.
    // The caller is at a negedge with instance A idle.
    task automatic send_a(input string tag, input logic [7:0] d);
        a_data  = d;
        a_valid = 1'b1;
        for (int k = 1; k <= 41; k++) begin
            @(negedge clk);
            if (k <= 40) begin
                check($sformatf("%s_tx_c%0d", tag, k), a_tx, exp_tx8(d, k));
                check($sformatf("%s_busy_c%0d", tag, k), a_busy, 1);
                check($sformatf("%s_ready_c%0d", tag, k), a_ready, 0);
            end else begin
                check($sformatf("%s_tx_idle", tag), a_tx, 1);
                check($sformatf("%s_busy_idle", tag), a_busy, 0);
                check($sformatf("%s_ready_idle", tag), a_ready, 1);
            end
            check($sformatf("%s_done_c%0d", tag, k), a_done, (k == 40) ? 1 : 0);
            if (k == 1) a_valid = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1);
    end

    initial begin
        int         done_cnt;
        logic [5:0] exp_b;
        logic       want_tx;

        // Reset, with valid offered on both instances.
        rst     = 1'b1;
        a_valid = 1'b1;
        a_data  = 8'hFF;
        b_valid = 1'b1;
        b_data  = 4'hF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_tx", a_tx, 1);
            check("rst_busy", a_busy, 0);
            check("rst_done", a_done, 0);
            check("rst_ready", a_ready, 0);
            check("rst_b_ready", b_ready, 0);
            check("rst_b_tx", b_tx, 1);
        end
        rst     = 1'b0;
        a_valid = 1'b0;
        b_valid = 1'b0;
        @(negedge clk);
        check("rel_ready", a_ready, 1);
        check("rel_tx", a_tx, 1);
        check("rel_busy", a_busy, 0);
        check("rel_b_ready", b_ready, 1);

        // Single frame with data 0xA5.
        send_a("a5", 8'hA5);

        // Back-to-back frames: 0x00, then 0xFF, with valid held high.
        a_data  = 8'h00;
        a_valid = 1'b1;
        for (int k = 1; k <= 82; k++) begin
            @(negedge clk);
            if (k <= 40)      want_tx = exp_tx8(8'h00, k);
            else if (k == 41) want_tx = 1'b1;
            else if (k <= 81) want_tx = exp_tx8(8'hFF, k - 41);
            else              want_tx = 1'b1;
            check($sformatf("b2b_tx_c%0d", k), a_tx, want_tx);
            check($sformatf("b2b_done_c%0d", k), a_done, (k == 40 || k == 81) ? 1 : 0);
            check($sformatf("b2b_ready_c%0d", k), a_ready, (k == 41 || k == 82) ? 1 : 0);
            if (k == 1)  a_data  = 8'hFF;
            if (k == 42) a_valid = 1'b0;
        end

        // Frame 0x3C, with i_data and i_valid disturbed while busy.
        a_data   = 8'h3C;
        a_valid  = 1'b1;
        done_cnt = 0;
        for (int k = 1; k <= 41; k++) begin
            @(negedge clk);
            if (k <= 40) check($sformatf("ign_tx_c%0d", k), a_tx, exp_tx8(8'h3C, k));
            if (a_done) done_cnt++;
            if (k == 1) a_valid = 1'b0;
            if (k == 6 || k == 14 || k == 22 || k == 30) begin
                a_data  = 8'($urandom);
                a_valid = 1'b1;
            end
            if (k == 7 || k == 15 || k == 23 || k == 31) a_valid = 1'b0;
        end
        check("ign_done_count", done_cnt, 1);
        check("ign_ready_after", a_ready, 1);

        // Frame 0x96, with reset asserted for one cycle at frame cycle 15.
        a_data  = 8'h96;
        a_valid = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            @(negedge clk);
            check($sformatf("mrst_done_c%0d", k), a_done, 0);
            if (k <= 15) check($sformatf("mrst_tx_c%0d", k), a_tx, exp_tx8(8'h96, k));
            if (k == 16) begin
                check("mrst_tx_after", a_tx, 1);
                check("mrst_busy_after", a_busy, 0);
                check("mrst_ready_in_rst", a_ready, 0);
            end
            if (k == 17) begin
                check("mrst_ready_release", a_ready, 1);
                check("mrst_tx_release", a_tx, 1);
            end
            if (k == 1)  a_valid = 1'b0;
            if (k == 15) rst = 1'b1;
            if (k == 16) rst = 1'b0;
        end
        send_a("post", 8'hC3);

        // Instance B: CLKS_PER_BIT=1, DATA_WIDTH=4, data 0x6 -> 0,0,1,1,0,1.
        exp_b   = 6'b101100;
        b_data  = 4'h6;
        b_valid = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            if (k <= 6) begin
                check($sformatf("b_tx_c%0d", k), b_tx, exp_b[k-1]);
                check($sformatf("b_ready_c%0d", k), b_ready, 0);
            end else begin
                check("b_ready_after", b_ready, 1);
                check("b_tx_after", b_tx, 1);
            end
            check($sformatf("b_done_c%0d", k), b_done, (k == 6) ? 1 : 0);
            if (k == 1) b_valid = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
